// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - register map constants and shared types for the DMA register front end
package dma_pkg;
  localparam int NCH_DEF = 4;
  localparam int AW_DEF  = 16;

  localparam logic [3:0] ADDR_CMD     = 4'h8;
  localparam logic [3:0] ADDR_REQ     = 4'h9;
  localparam logic [3:0] ADDR_SMASK   = 4'hA;
  localparam logic [3:0] ADDR_MODE    = 4'hB;
  localparam logic [3:0] ADDR_CLRFF   = 4'hC;
  localparam logic [3:0] ADDR_MCLR    = 4'hD;
  localparam logic [3:0] ADDR_CLRMASK = 4'hE;
  localparam logic [3:0] ADDR_WRMASK  = 4'hF;

  localparam int MODE_AUTOINIT = 4;
  localparam int MODE_DEC      = 5;
  localparam int CMD_MEM2MEM   = 0;
  localparam int CMD_DISABLE   = 2;

  typedef logic [NCH_DEF-1:0][AW_DEF-1:0] ch_reg_t;
  typedef logic [NCH_DEF-1:0][7:0]        mode_reg_t;
endpackage

// File: rtl/dma_strobe_edge.sv
// rtl/dma_strobe_edge.sv - first-cycle detector for one CPU access strobe
module dma_strobe_edge (
  input  logic clk,
  input  logic rst,
  input  logic act,
  input  logic block,
  output logic pulse
);
  logic act_q;

  // Resetting to 1 means a strobe held through reset must drop before it counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) act_q <= 1'b1;
    else     act_q <= act;
  end

  assign pulse = act & ~act_q & ~block;
endmodule

// File: rtl/dma_reg_prog.sv
// rtl/dma_reg_prog.sv - CPU programming front end for an 8237A-style DMA controller
module dma_reg_prog
  import dma_pkg::*;
#(
  parameter int NCH = 4,
  parameter int AW  = 16
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    CS_N,
  input  logic                    IOR_N,
  input  logic                    IOW_N,
  input  logic [3:0]              A,
  input  logic [7:0]              DB_IN,
  output logic [7:0]              DB_OUT,
  output logic                    DB_OE,
  input  logic [NCH-1:0]          TC_IN,
  input  logic [NCH-1:0]          DREQ_IN,
  input  logic                    UPD_EN,
  input  logic [1:0]              UPD_CH,
  input  logic [AW-1:0]           UPD_ADDR,
  input  logic [AW-1:0]           UPD_WORD,
  output logic [NCH-1:0][AW-1:0]  CUR_ADDR,
  output logic [NCH-1:0][AW-1:0]  CUR_WORD,
  output logic [NCH-1:0][AW-1:0]  BASE_ADDR,
  output logic [NCH-1:0][AW-1:0]  BASE_WORD,
  output logic [NCH-1:0][7:0]     MODE,
  output logic [7:0]              COMMAND,
  output logic [7:0]              REQUEST,
  output logic [7:0]              MASK,
  output logic [7:0]              TEMP,
  output logic [7:0]              STATUS
);
  logic wr_act, rd_act, wr_pulse, rd_pulse;
  logic ch_wr, ch_rd, mclr, ff;
  logic [1:0] sel;
  logic [3:0] tc_q, tc_n;
  logic [7:0] rd_data;
  logic [NCH-1:0][AW-1:0] cur_addr_n, cur_word_n, base_addr_n, base_word_n;

  assign wr_act = ~CS_N & ~IOW_N;
  assign rd_act = ~CS_N & ~IOR_N;

  dma_strobe_edge u_wr_edge (.clk(CLK), .rst(RESET), .act(wr_act), .block(rd_act), .pulse(wr_pulse));
  dma_strobe_edge u_rd_edge (.clk(CLK), .rst(RESET), .act(rd_act), .block(wr_act), .pulse(rd_pulse));

  assign sel   = A[2:1];
  assign ch_wr = wr_pulse & ~A[3];
  assign ch_rd = rd_pulse & ~A[3];
  assign mclr  = wr_pulse & (A == ADDR_MCLR);

  assign STATUS = {DREQ_IN | REQUEST[3:0], tc_q};
  // A status read clears TC bits, but a TC arriving in the same cycle survives.
  assign tc_n = (tc_q & ~{4{rd_pulse & (A == ADDR_CMD)}}) | TC_IN;

  always_comb begin
    rd_data = 8'h00;
    if (!A[3]) begin
      if (A[0]) rd_data = ff ? CUR_WORD[sel][15:8] : CUR_WORD[sel][7:0];
      else      rd_data = ff ? CUR_ADDR[sel][15:8] : CUR_ADDR[sel][7:0];
    end else if (A == ADDR_CMD) begin
      rd_data = STATUS;
    end else if (A == ADDR_MCLR) begin
      rd_data = TEMP;
    end
  end

  // Current registers: CPU byte write over autoinit reload over engine update.
  always_comb begin
    cur_addr_n  = CUR_ADDR;
    cur_word_n  = CUR_WORD;
    base_addr_n = BASE_ADDR;
    base_word_n = BASE_WORD;
    for (int c = 0; c < NCH; c++) begin
      if (UPD_EN && UPD_CH == 2'(c)) begin
        cur_addr_n[c] = UPD_ADDR;
        cur_word_n[c] = UPD_WORD;
      end
      if (TC_IN[c] && MODE[c][MODE_AUTOINIT]) begin
        cur_addr_n[c] = BASE_ADDR[c];
        cur_word_n[c] = BASE_WORD[c];
      end
      if (ch_wr && sel == 2'(c)) begin
        if (!A[0]) begin
          if (ff) begin cur_addr_n[c][15:8] = DB_IN; base_addr_n[c][15:8] = DB_IN; end
          else    begin cur_addr_n[c][7:0]  = DB_IN; base_addr_n[c][7:0]  = DB_IN; end
        end else begin
          if (ff) begin cur_word_n[c][15:8] = DB_IN; base_word_n[c][15:8] = DB_IN; end
          else    begin cur_word_n[c][7:0]  = DB_IN; base_word_n[c][7:0]  = DB_IN; end
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      CUR_ADDR  <= '0;
      CUR_WORD  <= '0;
      BASE_ADDR <= '0;
      BASE_WORD <= '0;
      MODE      <= '0;
    end else begin
      CUR_ADDR  <= cur_addr_n;
      CUR_WORD  <= cur_word_n;
      BASE_ADDR <= base_addr_n;
      BASE_WORD <= base_word_n;
      if (wr_pulse && A == ADDR_MODE) MODE[DB_IN[1:0]] <= DB_IN;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      COMMAND <= 8'h00;
      REQUEST <= 8'h00;
      MASK    <= 8'h0F;
      TEMP    <= 8'h00;
      tc_q    <= 4'h0;
      ff      <= 1'b0;
      DB_OUT  <= 8'h00;
      DB_OE   <= 1'b0;
    end else begin
      DB_OE <= rd_act;
      tc_q  <= tc_n;
      if (rd_pulse) DB_OUT <= rd_data;
      if (wr_pulse && A == ADDR_CLRFF) ff <= 1'b0;
      else if (ch_wr || ch_rd)         ff <= ~ff;
      if (wr_pulse) begin
        case (A)
          ADDR_CMD:     COMMAND <= DB_IN;
          ADDR_REQ:     REQUEST[{1'b0, DB_IN[1:0]}] <= DB_IN[2];
          ADDR_SMASK:   MASK[{1'b0, DB_IN[1:0]}] <= DB_IN[2];
          ADDR_CLRMASK: MASK[3:0] <= 4'h0;
          ADDR_WRMASK:  MASK[3:0] <= DB_IN[3:0];
          default: ;
        endcase
      end
      for (int c = 0; c < NCH; c++) begin
        if (TC_IN[c]) begin
          REQUEST[c] <= 1'b0;
          if (!MODE[c][MODE_AUTOINIT]) MASK[c] <= 1'b1;
        end
      end
      if (mclr) begin
        COMMAND <= 8'h00;
        REQUEST <= 8'h00;
        MASK    <= 8'h0F;
        TEMP    <= 8'h00;
        tc_q    <= 4'h0;
        ff      <= 1'b0;
        DB_OUT  <= 8'h00;
        DB_OE   <= 1'b0;
      end
    end
  end
endmodule

// File: doc/dma_reg_prog.md
Name: dma_reg_prog

Overview:
- CPU-side programming front end of the 8237A-compatible DMA controller.
- Decodes the 4-bit I/O address and the CS_N/IOR_N/IOW_N strobes, maintains the byte-pointer flip-flop, and writes the per-channel address, word, mode, command, request, mask and temp registers.
- Drives these values onto the register interface that the transfer timing/priority logic consumes. Returns status and current-register readback to the CPU.

Parameters:
- NCH, 4, number of DMA channels (channel select field is 2 bits; only 4 is supported).
- AW, 16, address and word register width.

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous active-high reset
- CS_N  in  1  chip select, active low
- IOR_N  in  1  CPU read strobe, active low
- IOW_N  in  1  CPU write strobe, active low
- A  in  4  register address
- DB_IN  in  8  CPU write data
- DB_OUT  out  8  CPU read data, registered
- DB_OE  out  1  read-data drive enable
- TC_IN  in  4  one-cycle terminal-count pulse per channel, from the transfer engine
- DREQ_IN  in  4  synchronized DREQ levels
- UPD_EN  in  1  transfer-engine update of current registers
- UPD_CH  in  2  channel being updated
- UPD_ADDR  in  16  new current address
- UPD_WORD  in  16  new current word count
- CUR_ADDR, CUR_WORD, BASE_ADDR, BASE_WORD  out  4x16 each  per-channel registers
- MODE  out  4x8  per-channel mode registers
- COMMAND, REQUEST, MASK, TEMP, STATUS  out  8 each

Behaviour:
- Reset, and master clear (write to A=0xD):
  - COMMAND, REQUEST, STATUS, TEMP = 0; byte-pointer flip-flop (FF) = 0; MASK = 0x0F.
  - DB_OUT = 0, DB_OE = 0.
  - Addr/word/mode registers = 0 on RESET only; master clear leaves them unchanged.
- Access detection:
  - wr_act = !CS_N & !IOW_N; rd_act = !CS_N & !IOR_N. Both are registered for edge detection.
  - wr_pulse / rd_pulse is asserted on the first cycle of the active level, so each access commits exactly once however long the strobe is held.
  - If wr_act and rd_act are both true, neither pulse fires (illegal access is ignored).
- Writes on wr_pulse:
  - A=0,2,4,6 (channel A[2:1] address) and A=1,3,5,7 (word): the byte (low when FF=0, high when FF=1) is written to both the base and current register; FF toggles.
  - 0x8: COMMAND <= DB_IN.
  - 0x9: REQUEST[DB_IN[1:0]] <= DB_IN[2].
  - 0xA: MASK[DB_IN[1:0]] <= DB_IN[2].
  - 0xB: MODE[DB_IN[1:0]] <= DB_IN.
  - 0xC: FF <= 0.
  - 0xD: master clear.
  - 0xE: MASK[3:0] <= 0.
  - 0xF: MASK[3:0] <= DB_IN[3:0].
- Reads on rd_pulse:
  - DB_OUT latches the selected data on the next edge. Data is valid 1 cycle after rd_act rises and is held until the next rd_pulse.
  - DB_OE = rd_act delayed by 1 cycle.
  - 0–7: current address/word byte selected by FF; FF toggles.
  - 0x8: STATUS; TC bits STATUS[3:0] are cleared after the latch.
  - 0xD: TEMP.
  - Any other address: 0x00, no side effects.
- STATUS:
  - [7:4] = DREQ_IN | REQUEST[3:0], combinational each cycle.
  - [3:0] set by TC_IN. A set and a status-read clear in the same cycle: set wins, and the latched value shows the pre-set bit.
- On TC_IN[ch]:
  - REQUEST[ch] <= 0.
  - If MODE[ch][4] (autoinit) = 1: CUR_ADDR/CUR_WORD[ch] <= BASE_ADDR/BASE_WORD[ch].
  - Otherwise MASK[ch] <= 1.
- Current-register priority per channel, highest first: CPU write, autoinit reload, UPD_EN. A CPU write updates only the addressed byte; the other byte keeps the value of the next-priority source.
- Master clear coinciding with TC_IN: master-clear values win for COMMAND, REQUEST, STATUS, TEMP and MASK.
- RESET asserted mid-access: all state returns to reset values. An access still active at deassertion does not generate a pulse until the strobe goes inactive and then active again. Edge registers reset to 1 (treated as already active).

Decomposition:
- dma_pkg: register-address constants (ADDR_CMD=4'h8 … ADDR_WRMASK=4'hF), MODE/COMMAND bit-index constants, and a typedef for the 4x16 channel register array.
- One sub-module, dma_strobe_edge: per-strobe synchronous edge detector, instanced twice for read and write.

Test Plan:
- Reset → MASK=0x0F, STATUS=0, DB_OE=0; write 0xC; write 0x34 then 0x12 to A=2 → BASE_ADDR[1]=CUR_ADDR[1]=0x1234.
- Read A=2 twice → DB_OUT=0x34 then 0x12; a third read (FF wrapped) → 0x34.
- Write mode 0x56 (ch2, autoinit); UPD_EN ch2 addr 0x1000; pulse TC_IN[2] → CUR_ADDR[2] reloads the base value, MASK[2] stays 0, STATUS=0x04.
- TC_IN[0] with autoinit off → MASK[0]=1, STATUS[0]=1. Read A=8 → DB_OUT has bit0=1; a second read → bit0=0.
- TC_IN[1] in the same cycle as a status read → latched bit1=0 and STATUS[1]=1 afterwards. Hold IOW_N low 10 cycles on A=0 → FF toggles exactly once.
- Write request 0x05 → REQUEST[1]=1, STATUS[5]=1. Master clear during the access → MASK=0x0F, REQUEST=0, BASE regs unchanged.
